qk_vector_streamer: RTL and testbench

- Producer side of the dot_product Q/K input handshake; reads Q and K vectors from on-chip tile buffers and drives q/k with valid/ready.
- For each of NUM_Q query rows: presents one Q vector, then streams all NUM_K key vectors for that row in ascending address order.
- Sits between the Q/K tile SRAMs and the dot_product array; started by the tile controller and pulses done when the whole tile has been issued.

---
 rtl/qk_vector_streamer.sv | 195 +++++++++++++++++++
 tb/tb_qk_vector_streamer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qk_vector_streamer.sv
// qk_vector_streamer: producer side of the dot_product Q/K handshake.
// For each query row it reads one Q vector from the Q tile buffer and presents it.
// It then streams all NUM_K key vectors of that row from the K tile buffer,
// through a 2-entry K FIFO.
// Optional build macro QK_STREAM_PERF_EN adds the k_stall_cnt output, which counts
// cycles where K is offered but not accepted.
//
// state      | meaning
// S_IDLE     | waiting for start
// S_LOAD_Q   | Q buffer read strobe for the current row
// S_Q_WAIT   | capture Q read data, then hold q_out until the consumer accepts it
// S_STREAM_K | stream the row's K vectors out of the FIFO
// S_DONE     | one-cycle done pulse, then back to idle
module qk_vector_streamer #(
    parameter int NUM_Q             = 4,
    parameter int NUM_K             = 8,
    parameter int MAX_EMBEDDING_DIM = 4,
    parameter int INTEGER_WIDTH     = 8,
    parameter int Q_ADDR_W          = (NUM_Q > 1) ? $clog2(NUM_Q) : 1,
    parameter int K_ADDR_W          = (NUM_K > 1) ? $clog2(NUM_K) : 1,
    parameter int VEC_W             = MAX_EMBEDDING_DIM * INTEGER_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                q_rd_en,
    output logic [Q_ADDR_W-1:0] q_rd_addr,
    input  logic [VEC_W-1:0]    q_rd_data,
    output logic                k_rd_en,
    output logic [K_ADDR_W-1:0] k_rd_addr,
    input  logic [VEC_W-1:0]    k_rd_data,
    output logic                Q_vld_out,
    input  logic                Q_rdy_in,
    output logic [VEC_W-1:0]    q_out,
    output logic                K_vld_out,
    input  logic                K_rdy_in,
    output logic [VEC_W-1:0]    k_out
`ifdef QK_STREAM_PERF_EN
    ,
    output logic [31:0]         k_stall_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_Q, S_Q_WAIT, S_STREAM_K, S_DONE} state_t;

    localparam logic [Q_ADDR_W-1:0] LAST_Q = Q_ADDR_W'(NUM_Q - 1);
    localparam logic [K_ADDR_W-1:0] LAST_K = K_ADDR_W'(NUM_K - 1);

    state_t                r_state;
    logic                  r_busy, r_done, r_q_rd_en, r_q_vld;
    logic [Q_ADDR_W-1:0]   r_q_row;
    logic [VEC_W-1:0]      r_q_out;
    logic [K_ADDR_W-1:0]   r_k_idx, r_k_acc;
    logic                  r_k_all, r_k_pend;
    logic [1:0]            r_k_cnt;
    logic [VEC_W-1:0]      r_kf0, r_kf1;

    logic                  w_q_xfer, w_row_open, w_k_vld, w_k_pop, w_k_last;
    logic                  w_k_fetch_st, w_k_room, w_k_issue;
    logic [2:0]            w_k_occ;

    // K may go valid in the same cycle the row's Q is accepted, never earlier.
    assign w_q_xfer     = r_q_vld && Q_rdy_in;
    assign w_row_open   = (r_state == S_STREAM_K) || ((r_state == S_Q_WAIT) && w_q_xfer);
    assign w_k_vld      = (r_k_cnt != 2'd0) && w_row_open;
    assign w_k_pop      = w_k_vld && K_rdy_in;
    assign w_k_last     = w_k_pop && (r_k_acc == LAST_K);

    // Entries held plus the read returning this cycle; a pop frees a slot in time
    // for a read issued now, which is what sustains one K per cycle.
    assign w_k_occ      = {1'b0, r_k_cnt} + {2'b00, r_k_pend};
    assign w_k_room     = (w_k_occ < 3'd2) || (w_k_pop && (w_k_occ == 3'd2));
    assign w_k_fetch_st = (r_state == S_LOAD_Q) || (r_state == S_Q_WAIT) || (r_state == S_STREAM_K);
    assign w_k_issue    = w_k_fetch_st && !r_k_all && w_k_room;

    // Row/tile sequencing, Q read and Q output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_q_rd_en <= 1'b0;
            r_q_vld   <= 1'b0;
            r_q_row   <= '0;
            r_q_out   <= '0;
        end else begin
            r_done    <= 1'b0;
            r_q_rd_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_LOAD_Q;
                        r_busy    <= 1'b1;
                        r_q_row   <= '0;
                        r_q_rd_en <= 1'b1;
                    end
                end
                S_LOAD_Q: r_state <= S_Q_WAIT;
                S_Q_WAIT: begin
                    if (!r_q_vld) begin
                        r_q_out <= q_rd_data;
                        r_q_vld <= 1'b1;
                    end else if (w_q_xfer) begin
                        r_q_vld <= 1'b0;
                        r_state <= S_STREAM_K;
                    end
                end
                S_STREAM_K: ;
                S_DONE:   r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
            // Last K of a row accepted: next row or finish (may happen in Q_WAIT when NUM_K=1).
            if (w_k_last) begin
                if (r_q_row == LAST_Q) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end else begin
                    r_state   <= S_LOAD_Q;
                    r_q_row   <= r_q_row + 1'b1;
                    r_q_rd_en <= 1'b1;
                end
            end
        end
    end

    // K read issue, accept counting and the 2-entry K FIFO (head in r_kf0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k_idx  <= '0;
            r_k_acc  <= '0;
            r_k_all  <= 1'b0;
            r_k_pend <= 1'b0;
            r_k_cnt  <= 2'd0;
            r_kf0    <= '0;
            r_kf1    <= '0;
        end else begin
            r_k_pend <= w_k_issue;
            if (w_k_issue)
                r_k_idx <= (r_k_idx == LAST_K) ? '0 : r_k_idx + 1'b1;
            if (w_k_last)
                r_k_all <= 1'b0;
            else if (w_k_issue && (r_k_idx == LAST_K))
                r_k_all <= 1'b1;
            if (w_k_pop)
                r_k_acc <= w_k_last ? '0 : r_k_acc + 1'b1;
            case ({r_k_pend, w_k_pop})
                2'b10: begin
                    if (r_k_cnt == 2'd0) r_kf0 <= k_rd_data;
                    else                 r_kf1 <= k_rd_data;
                    r_k_cnt <= r_k_cnt + 2'd1;
                end
                2'b01: begin
                    r_kf0   <= r_kf1;
                    r_k_cnt <= r_k_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_k_cnt == 2'd1) begin
                        r_kf0 <= k_rd_data;
                    end else begin
                        r_kf0 <= r_kf1;
                        r_kf1 <= k_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef QK_STREAM_PERF_EN
    // Saturating count of K stall cycles, restarted by each accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            k_stall_cnt <= '0;
        else if ((r_state == S_IDLE) && start)
            k_stall_cnt <= '0;
        else if (w_k_vld && !K_rdy_in && (k_stall_cnt != 32'hFFFF_FFFF))
            k_stall_cnt <= k_stall_cnt + 32'd1;
    end
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign q_rd_en   = r_q_rd_en;
    assign q_rd_addr = r_q_row;
    assign k_rd_en   = w_k_issue;
    assign k_rd_addr = r_k_idx;
    assign Q_vld_out = r_q_vld;
    assign q_out     = r_q_out;
    assign K_vld_out = w_k_vld;
    assign k_out     = r_kf0;

endmodule

// File: tb/tb_qk_vector_streamer.sv
// Bench for qk_vector_streamer: table of tile scenarios plus random tiles, checked
// against a transfer-order scoreboard; QK_STREAM_PERF_EN enables the stall-count check.
module tb_qk_vector_streamer;

    localparam int NQ = 2;
    localparam int NK = 4;
    localparam int VW = 32;

    logic clk = 1'b0;
    logic rst, start;
    logic busy, done, q_rd_en, k_rd_en;
    logic [0:0] q_rd_addr;
    logic [1:0] k_rd_addr;
    logic [VW-1:0] q_rd_data = '0, k_rd_data = '0;
    logic Q_vld_out, Q_rdy_in, K_vld_out, K_rdy_in;
    logic [VW-1:0] q_out, k_out;
`ifdef QK_STREAM_PERF_EN
    logic [31:0] k_stall_cnt, b_stall_cnt;
`endif

    logic b_start, b_busy, b_done, b_q_rd_en, b_k_rd_en;
    logic [0:0] b_q_rd_addr, b_k_rd_addr;
    logic [VW-1:0] b_q_rd_data = '0, b_k_rd_data = '0;
    logic b_Q_vld, b_K_vld, b_q_rdy, b_k_rdy;
    logic [VW-1:0] b_q_out, b_k_out;
    logic [VW-1:0] bq = 32'h5A5A_5A5A;
    logic [VW-1:0] bk = 32'hC3C3_C3C3;

    logic [VW-1:0] qbuf [NQ];
    logic [VW-1:0] kbuf [NK];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    qk_vector_streamer #(.NUM_Q(NQ), .NUM_K(NK), .MAX_EMBEDDING_DIM(4), .INTEGER_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data),
        .k_rd_en(k_rd_en), .k_rd_addr(k_rd_addr), .k_rd_data(k_rd_data),
        .Q_vld_out(Q_vld_out), .Q_rdy_in(Q_rdy_in), .q_out(q_out),
        .K_vld_out(K_vld_out), .K_rdy_in(K_rdy_in), .k_out(k_out)
`ifdef QK_STREAM_PERF_EN
        , .k_stall_cnt(k_stall_cnt)
`endif
    );

    qk_vector_streamer #(.NUM_Q(1), .NUM_K(1), .MAX_EMBEDDING_DIM(4), .INTEGER_WIDTH(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .q_rd_en(b_q_rd_en), .q_rd_addr(b_q_rd_addr), .q_rd_data(b_q_rd_data),
        .k_rd_en(b_k_rd_en), .k_rd_addr(b_k_rd_addr), .k_rd_data(b_k_rd_data),
        .Q_vld_out(b_Q_vld), .Q_rdy_in(b_q_rdy), .q_out(b_q_out),
        .K_vld_out(b_K_vld), .K_rdy_in(b_k_rdy), .k_out(b_k_out)
`ifdef QK_STREAM_PERF_EN
        , .k_stall_cnt(b_stall_cnt)
`endif
    );

    // Tile buffers with one-cycle read latency.
    always @(posedge clk) begin
        if (q_rd_en)   q_rd_data   <= qbuf[q_rd_addr];
        if (k_rd_en)   k_rd_data   <= kbuf[k_rd_addr];
        if (b_q_rd_en) b_q_rd_data <= bq;
        if (b_k_rd_en) b_k_rd_data <= bk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_le(input string nm, input int act, input int lim);
        n_total++;
        if (act > lim) begin
            n_bad++;
            $display("FAIL %s: got %0d expected <= %0d", nm, act, lim);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Consumer ready generation: Q held off q_hold cycles after valid; K per mode.
    int k_mode = 0, q_hold = 0, qv_cnt = 0, cyc_d = 0;
    logic [3:0] tog = 4'b1001;
    initial begin : rdy_drv
        Q_rdy_in = 1'b0;
        K_rdy_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (Q_vld_out) qv_cnt++; else qv_cnt = 0;
            Q_rdy_in = (qv_cnt > q_hold);
            case (k_mode)
                0: K_rdy_in = 1'b1;
                1: K_rdy_in = tog[cyc_d % 4];
                default: begin
                    K_rdy_in = ($urandom_range(0, 1) == 1);
                    Q_rdy_in = (qv_cnt > q_hold) && ($urandom_range(0, 1) == 1);
                end
            endcase
            cyc_d++;
        end
    end

    // Scoreboard: expected transfer order is Q[r] then K[0..NK-1] for r = 0..NQ-1.
    logic mon_en = 1'b0;
    int q_x, k_x, done_n, stall_n, run, max_run, rd_n, last_k_cyc, cyc = 0;
    logic pq_vld, pk_vld, pq_x, pk_x;
    logic [VW-1:0] pq_data, pk_data;

    task automatic model_clear;
        q_x = 0; k_x = 0; done_n = 0; stall_n = 0; run = 0; max_run = 0; rd_n = 0;
        last_k_cyc = -10;
        pq_vld = 1'b0; pk_vld = 1'b0; pq_x = 1'b0; pk_x = 1'b0;
        pq_data = '0; pk_data = '0;
    endtask

    always @(negedge clk) begin : monitor
        logic w_qx, w_kx;
        cyc++;
        if (mon_en) begin
            w_qx = Q_vld_out && Q_rdy_in;
            w_kx = K_vld_out && K_rdy_in;
            if (pq_vld && !pq_x) begin
                chk("q_vld_held", Q_vld_out, 1);
                chk("q_data_held", q_out, pq_data);
            end
            if (pk_vld && !pk_x) begin
                chk("k_vld_held", K_vld_out, 1);
                chk("k_data_held", k_out, pk_data);
            end
            if (w_qx) begin
                if (q_x < NQ) chk("q_order", q_out, qbuf[q_x]);
                else          chk("q_count", q_x + 1, NQ);
                q_x++;
            end
            if (w_kx) begin
                if (k_x < NQ * NK) begin
                    chk("k_order", k_out, kbuf[k_x % NK]);
                    chk("k_after_q", q_x, k_x / NK + 1);
                end else begin
                    chk("k_count", k_x + 1, NQ * NK);
                end
                k_x++;
                run++;
                if (run > max_run) max_run = run;
                last_k_cyc = cyc;
            end else begin
                run = 0;
            end
            if (K_vld_out && !K_rdy_in) stall_n++;
            if (k_rd_en) begin
                rd_n++;
                chk_le("k_outstanding", rd_n - k_x, 2);
            end
            if (done) begin
                done_n++;
                chk("done_after_last_k", cyc - last_k_cyc, 1);
                chk("busy_low_on_done", busy, 0);
            end
            pq_vld = Q_vld_out; pq_x = w_qx; pq_data = q_out;
            pk_vld = K_vld_out; pk_x = w_kx; pk_data = k_out;
        end
    end

    typedef struct {
        int k_mode;
        int q_hold;
        bit poke;
        bit rnd_data;
        int exp_q;
        int exp_k;
        int exp_run;
    } vec_t;

    task automatic fill_fixed;
        for (int i = 0; i < NQ; i++) qbuf[i] = {4{8'(i + 1)}};
        for (int i = 0; i < NK; i++) kbuf[i] = {4{8'(i + 16)}};
    endtask

    task automatic run_tile(input vec_t t);
        k_mode = t.k_mode;
        q_hold = t.q_hold;
        if (t.rnd_data) begin
            for (int i = 0; i < NQ; i++) qbuf[i] = $urandom;
            for (int i = 0; i < NK; i++) kbuf[i] = $urandom;
        end else begin
            fill_fixed();
        end
        model_clear();
        mon_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < 400 && done_n == 0; i++) begin
            start = t.poke && (i == 5);
            tick();
        end
        start = 1'b0;
        repeat (3) tick();
        chk("done_pulses", done_n, 1);
        chk("q_xfers", q_x, t.exp_q);
        chk("k_xfers", k_x, t.exp_k);
        chk("busy_idle", busy, 0);
        if (t.exp_run != 0) chk("k_back_to_back", max_run, t.exp_run);
`ifdef QK_STREAM_PERF_EN
        chk("k_stall_cnt", k_stall_cnt, stall_n);
`endif
        mon_en = 1'b0;
    endtask

    vec_t tbl [6];
    int bqx, bkx, bdn, bkc, bdc;

    initial begin
        tbl[0] = '{0, 0, 1'b0, 1'b0, NQ, NQ * NK, NK};
        tbl[1] = '{1, 0, 1'b0, 1'b0, NQ, NQ * NK, 0};
        tbl[2] = '{0, 5, 1'b0, 1'b0, NQ, NQ * NK, NK};
        tbl[3] = '{0, 0, 1'b1, 1'b0, NQ, NQ * NK, NK};
        tbl[4] = '{1, 5, 1'b1, 1'b0, NQ, NQ * NK, 0};
        tbl[5] = '{2, 2, 1'b0, 1'b1, NQ, NQ * NK, 0};

        rst = 1'b1; start = 1'b1; b_start = 1'b1;
        b_q_rdy = 1'b1; b_k_rdy = 1'b1;
        fill_fixed();
        model_clear();
        @(posedge clk); @(posedge clk); #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q_rd_en", q_rd_en, 0);
        chk("rst_k_rd_en", k_rd_en, 0);
        chk("rst_q_addr", q_rd_addr, 0);
        chk("rst_k_addr", k_rd_addr, 0);
        chk("rst_q_vld", Q_vld_out, 0);
        chk("rst_k_vld", K_vld_out, 0);
        chk("rst_q_out", q_out, 0);
        chk("rst_k_out", k_out, 0);
`ifdef QK_STREAM_PERF_EN
        chk("rst_stall_cnt", k_stall_cnt, 0);
`endif
        start = 1'b0; b_start = 1'b0;
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) run_tile(tbl[v]);
        for (int r = 0; r < 4; r++)
            run_tile('{2, int'($urandom_range(0, 3)), 1'b0, 1'b1, NQ, NQ * NK, 0});

        // Reset mid-stream after two K transfers of row 0.
        k_mode = 0; q_hold = 0;
        fill_fixed();
        model_clear();
        mon_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && k_x < 2; i++) tick();
        chk("k_before_reset", k_x, 2);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_k_vld", K_vld_out, 0);
        chk("mid_rst_k_out", k_out, 0);
        chk("mid_rst_q_vld", Q_vld_out, 0);
        chk("mid_rst_q_out", q_out, 0);
        chk("mid_rst_k_rd_en", k_rd_en, 0);
        chk("mid_rst_k_addr", k_rd_addr, 0);
        tick();
        rst = 1'b0;
        tick();
        run_tile(tbl[0]);

        // Single-row, single-key tile.
        bqx = 0; bkx = 0; bdn = 0; bkc = -10; bdc = -20;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_Q_vld && b_q_rdy) begin
                bqx++;
                chk("b_q_data", b_q_out, bq);
            end
            if (b_K_vld && b_k_rdy) begin
                bkx++;
                bkc = i;
                chk("b_k_data", b_k_out, bk);
            end
            if (b_done) begin
                bdn++;
                bdc = i;
            end
        end
        chk("b_q_xfers", bqx, 1);
        chk("b_k_xfers", bkx, 1);
        chk("b_done_pulses", bdn, 1);
        chk("b_done_timing", bdc - bkc, 1);
        chk("b_busy_idle", b_busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
